ls298_rr_arbiter: RTL and testbench

- Controller that shares one quad 2-line-to-1 multiplexer-with-storage datapath between two requesters.
- Each requester presents a WIDTH-bit word with a request line.
- The block picks a requester round-robin, drives the mux select, captures the chosen word into the storage register, and acknowledges the winner.
- It buffers one captured word toward a downstream consumer with a valid/ready handshake.
- Sits between two producer blocks and a single consumer in the TTL model collection, modelling what a '298 plus glue logic would implement.

---
 rtl/ls298_rr_arbiter.sv | 142 ++++++++++++++
 tb/tb_ls298_rr_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/ls298_rr_arbiter.sv
// ls298_rr_arbiter
//
// Round-robin controller for one '298 quad 2-line-to-1 mux-with-storage datapath that is
// shared by two requesters. Each cycle it picks at most one pending requester and drives the
// mux select. It captures the selected word into the storage register and acknowledges the
// winner with a one-cycle pulse. It then presents the stored word to a single downstream
// consumer over a valid/ready handshake.
//
// Parameters
//   WIDTH  data word width (4 = one '298 package)
//   tPD    output propagation delay for the behavioural model. It is not modelled in this
//          synthesizable view and is only reported in assertion messages.
//
// Ports
//   clk      system clock, all state changes on the rising edge
//   rst      asynchronous active-high reset
//   req0     requester 0 has a word pending on din0 (din0 stable while req0=1)
//   din0     requester 0 data
//   req1     requester 1 has a word pending on din1 (din1 stable while req1=1)
//   din1     requester 1 data
//   ack0     one-cycle pulse, din0 was captured (coincident with the new q)
//   ack1     one-cycle pulse, din1 was captured (coincident with the new q)
//   sel      mux select as seen by the '298 S pin (0 = din0, 1 = din1)
//   q        storage register contents
//   q_valid  q holds a word the consumer has not yet taken
//   q_ready  consumer takes q this cycle when q_valid=1

module ls298_rr_arbiter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned tPD   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] din0,
  input  logic             req1,
  input  logic [WIDTH-1:0] din1,
  output logic             ack0,
  output logic             ack1,
  output logic             sel,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready
);

  // Storage register and handshake state
  logic [WIDTH-1:0] q_q, q_d;
  logic             q_valid_q, q_valid_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;

  // Round-robin pointer: index of the most recent winner
  logic             last_q, last_d;

  // Value sel rests at when nothing is granted. It tracks last after the first grant. It is
  // kept separate because reset puts last=1 (requester 0 wins the first tie) while the S pin
  // must come out of reset at 0.
  logic             sel_hold_q, sel_hold_d;

  // Grant decode
  logic             load_ok;
  logic             eff_req0;
  logic             eff_req1;
  logic             grant_valid;
  logic             grant_idx;

  // The register can accept a word when it is empty or is being drained this same cycle,
  // which gives one word per clock in steady state.
  assign load_ok = !q_valid_q || q_ready;

  // A requester that is being acknowledged this cycle is masked. Its req/data are still the
  // word just captured, and this masking stops it being captured twice.
  assign eff_req0 = req0 && !ack0_q;
  assign eff_req1 = req1 && !ack1_q;

  assign grant_valid = load_ok && (eff_req0 || eff_req1);

  always_comb begin
    grant_idx = 1'b0;
    if (eff_req0 && eff_req1) begin
      grant_idx = !last_q;
    end else if (eff_req1) begin
      grant_idx = 1'b1;
    end
  end

  always_comb begin
    q_d        = q_q;
    q_valid_d  = q_valid_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    last_d     = last_q;
    sel_hold_d = sel_hold_q;

    if (grant_valid) begin
      q_d        = grant_idx ? din1 : din0;
      q_valid_d  = 1'b1;
      last_d     = grant_idx;
      sel_hold_d = grant_idx;
      ack0_d     = !grant_idx;
      ack1_d     = grant_idx;
    end else if (q_valid_q && q_ready) begin
      // Consumed with nothing to replace it. q keeps its old value and is never cleared.
      q_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q        <= '0;
      q_valid_q  <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      last_q     <= 1'b1;
      sel_hold_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      q_valid_q  <= q_valid_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      last_q     <= last_d;
      sel_hold_q <= sel_hold_d;
    end
  end

  // sel follows the grant combinationally during the capture cycle, so the '298 sees the
  // right S value before the clock edge that loads it.
  assign sel     = grant_valid ? grant_idx : sel_hold_q;
  assign q       = q_q;
  assign q_valid = q_valid_q;
  assign ack0    = ack0_q;
  assign ack1    = ack1_q;

  // Simulation-only invariants
  a_ack_exclusive : assert property (@(posedge clk) disable iff (rst) !(ack0_q && ack1_q))
    else $error("ls298_rr_arbiter: ack0 and ack1 high together (tPD=%0d)", tPD);

  a_valid_held : assert property (@(posedge clk) disable iff (rst)
                                  (q_valid_q && !q_ready) |=> q_valid_q)
    else $error("ls298_rr_arbiter: q_valid dropped while q_ready=0 (tPD=%0d)", tPD);

endmodule

// File: tb/tb_ls298_rr_arbiter.sv
module tb_ls298_rr_arbiter;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1, q_ready;
  logic [W-1:0] din0, din1;
  logic         ack0, ack1, sel, q_valid;
  logic [W-1:0] q;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ls298_rr_arbiter #(
    .WIDTH(W),
    .tPD  (0)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req0   (req0),
    .din0   (din0),
    .req1   (req1),
    .din1   (din1),
    .ack0   (ack0),
    .ack1   (ack1),
    .sel    (sel),
    .q      (q),
    .q_valid(q_valid),
    .q_ready(q_ready)
  );

  // One row: inputs held for one clock, sel expected before the edge,
  // q/q_valid/acks expected after the edge.
  typedef struct {
    logic         req0;
    logic [W-1:0] din0;
    logic         req1;
    logic [W-1:0] din1;
    logic         rdy;
    logic         exp_sel;
    logic [W-1:0] exp_q;
    logic         exp_valid;
    logic         exp_ack0;
    logic         exp_ack1;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r0, input logic [W-1:0] d0, input logic r1,
                              input logic [W-1:0] d1, input logic rdy, input logic s,
                              input logic [W-1:0] eq, input logic ev, input logic ea0,
                              input logic ea1);
    vec_t v;
    v.req0 = r0; v.din0 = d0; v.req1 = r1; v.din1 = d1; v.rdy = rdy;
    v.exp_sel = s; v.exp_q = eq; v.exp_valid = ev; v.exp_ack0 = ea0; v.exp_ack1 = ea1;
    return v;
  endfunction

  initial begin
    //            r0 din0   r1 din1   rdy sel  q     vld a0 a1
    // single requester 0, then dropped after ack
    vecs[0]  = mk(1, 8'h0A, 0, 8'h00, 1, 0, 8'h0A, 1, 1, 0);
    vecs[1]  = mk(0, 8'h0A, 0, 8'h00, 1, 0, 8'h0A, 0, 0, 0);
    vecs[2]  = mk(0, 8'h00, 0, 8'h00, 0, 0, 8'h0A, 0, 0, 0);
    // tie with last=0: 1 wins first, then strict alternation
    vecs[3]  = mk(1, 8'h03, 1, 8'h0C, 1, 1, 8'h0C, 1, 0, 1);
    vecs[4]  = mk(1, 8'h03, 1, 8'h0C, 1, 0, 8'h03, 1, 1, 0);
    vecs[5]  = mk(1, 8'h03, 1, 8'h0C, 1, 1, 8'h0C, 1, 0, 1);
    vecs[6]  = mk(1, 8'h03, 1, 8'h0C, 1, 0, 8'h03, 1, 1, 0);
    vecs[7]  = mk(0, 8'h03, 0, 8'h0C, 0, 0, 8'h03, 1, 0, 0);
    // backpressure 5 cycles with req1 pending, then load on ready
    vecs[8]  = mk(0, 8'h00, 1, 8'h05, 0, 0, 8'h03, 1, 0, 0);
    vecs[9]  = mk(0, 8'h00, 1, 8'h05, 0, 0, 8'h03, 1, 0, 0);
    vecs[10] = mk(0, 8'h00, 1, 8'h05, 0, 0, 8'h03, 1, 0, 0);
    vecs[11] = mk(0, 8'h00, 1, 8'h05, 0, 0, 8'h03, 1, 0, 0);
    vecs[12] = mk(0, 8'h00, 1, 8'h05, 0, 0, 8'h03, 1, 0, 0);
    vecs[13] = mk(0, 8'h00, 1, 8'h05, 1, 1, 8'h05, 1, 0, 1);
    vecs[14] = mk(0, 8'h00, 0, 8'h05, 1, 1, 8'h05, 0, 0, 0);
    // q_ready while empty is ignored
    vecs[15] = mk(0, 8'h00, 0, 8'h00, 1, 1, 8'h05, 0, 0, 0);
    // full-width word from requester 1, then consume-and-load in one cycle
    vecs[16] = mk(0, 8'h00, 1, 8'hF0, 0, 1, 8'hF0, 1, 0, 1);
    vecs[17] = mk(0, 8'h00, 0, 8'hF0, 0, 1, 8'hF0, 1, 0, 0);
    vecs[18] = mk(1, 8'h5A, 0, 8'h00, 1, 0, 8'h5A, 1, 1, 0);
    vecs[19] = mk(0, 8'h5A, 0, 8'h00, 1, 0, 8'h5A, 0, 0, 0);

    // Reset and idle
    rst = 1'b1; req0 = 0; req1 = 0; din0 = '0; din1 = '0; q_ready = 0;
    #1;
    check("rst_q", 32'(q), 0);
    check("rst_valid", 32'(q_valid), 0);
    check("rst_ack0", 32'(ack0), 0);
    check("rst_ack1", 32'(ack1), 0);
    check("rst_sel", 32'(sel), 0);
    @(posedge clk); #3; rst = 1'b0; q_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check($sformatf("idle%0d_valid", i), 32'(q_valid), 0);
      check($sformatf("idle%0d_acks", i), 32'({ack0, ack1}), 0);
      check($sformatf("idle%0d_q", i), 32'(q), 0);
      check($sformatf("idle%0d_sel", i), 32'(sel), 0);
    end

    // Table
    for (int i = 0; i < NV; i++) begin
      req0 = vecs[i].req0; din0 = vecs[i].din0;
      req1 = vecs[i].req1; din1 = vecs[i].din1;
      q_ready = vecs[i].rdy;
      #1;
      check($sformatf("v%0d_sel", i), 32'(sel), 32'(vecs[i].exp_sel));
      @(posedge clk); #1;
      check($sformatf("v%0d_q", i), 32'(q), 32'(vecs[i].exp_q));
      check($sformatf("v%0d_valid", i), 32'(q_valid), 32'(vecs[i].exp_valid));
      check($sformatf("v%0d_ack0", i), 32'(ack0), 32'(vecs[i].exp_ack0));
      check($sformatf("v%0d_ack1", i), 32'(ack1), 32'(vecs[i].exp_ack1));
    end

    // Async reset in the ack0 cycle, then recapture of the still-pending word
    req0 = 1'b1; din0 = 8'h77; req1 = 1'b0; q_ready = 1'b1;
    @(posedge clk); #1;
    check("mr_pre_ack0", 32'(ack0), 1);
    check("mr_pre_q", 32'(q), 32'h77);
    #2; rst = 1'b1; #1;
    check("mr_ack0", 32'(ack0), 0);
    check("mr_q", 32'(q), 0);
    check("mr_valid", 32'(q_valid), 0);
    #2; rst = 1'b0;
    @(posedge clk); #1;
    check("mr_re_ack0", 32'(ack0), 1);
    check("mr_re_q", 32'(q), 32'h77);
    check("mr_re_valid", 32'(q_valid), 1);
    req0 = 1'b0;
    @(posedge clk); #1;
    check("mr_end_valid", 32'(q_valid), 0);
    check("mr_end_ack0", 32'(ack0), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Acks must never overlap anywhere in the run
  always @(negedge clk) begin
    if (rst === 1'b0 && ack0 === 1'b1 && ack1 === 1'b1) begin
      total++;
      bad++;
      $display("FAIL ack_overlap: got ack0=1 ack1=1 expected at most one");
    end
  end

endmodule
